// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64 MEM stage: aligned load/store over req/ack bus with timeout
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_instruction,
  output logic [63:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [2:0]  lane_off;
  logic        pend_load;
  logic [31:0] pend_instr;

  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic [1:0] size;
  logic [2:0] addr_lo;
  logic       misaligned;
  logic [7:0] strb_base;
  logic       accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_load  = (in_instruction[6:0] == 7'b0000011);
  assign is_store = (in_instruction[6:0] == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign size     = in_instruction[13:12];
  assign addr_lo  = in_alu_result[2:0];

  // Access size decode: alignment check and unshifted byte-enable pattern
  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h01;
    case (size)
      2'b00: begin misaligned = 1'b0;               strb_base = 8'h01; end
      2'b01: begin misaligned = addr_lo[0];         strb_base = 8'h03; end
      2'b10: begin misaligned = |addr_lo[1:0];      strb_base = 8'h0F; end
      default: begin misaligned = |addr_lo;         strb_base = 8'hFF; end
    endcase
  end

  // Stage FSM: accept, issue bus request, complete on ack or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      lane_off       <= '0;
      pend_load      <= 1'b0;
      pend_instr     <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      wb_valid       <= 1'b0;
      wb_instruction <= '0;
      wb_data        <= '0;
      wb_misalign    <= 1'b0;
      wb_bus_err     <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && misaligned) begin
              wb_valid       <= 1'b1;
              wb_misalign    <= 1'b1;
              wb_data        <= '0;
              wb_instruction <= in_instruction;
            end else if (is_mem) begin
              state      <= BUS;
              wait_cnt   <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {in_alu_result[63:3], 3'b000};
              dmem_wdata <= in_store_data << {addr_lo, 3'b000};
              dmem_wstrb <= is_store ? (strb_base << addr_lo) : 8'h00;
              lane_off   <= addr_lo;
              pend_load  <= is_load;
              pend_instr <= in_instruction;
            end else begin
              wb_valid       <= 1'b1;
              wb_data        <= in_alu_result;
              wb_instruction <= in_instruction;
            end
          end
        end
        BUS: begin
          // An ack in the final wait cycle still wins over the timeout
          if (dmem_ack) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            wb_valid       <= 1'b1;
            wb_instruction <= pend_instr;
            wb_data        <= pend_load ? (dmem_rdata >> {lane_off, 3'b000}) : 64'd0;
          end else if (wait_cnt == LAST_WAIT) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            wb_valid       <= 1'b1;
            wb_bus_err     <= 1'b1;
            wb_instruction <= pend_instr;
            wb_data        <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with reference model
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_instruction;
  logic [63:0] wb_data;
  logic        wb_misalign;
  logic        wb_bus_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_instruction(wb_instruction), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0]   = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Present one instruction from a negedge and follow it to its write-back.
  // ack_at: index of the bus wait cycle (0-based) in which ack is driven; >= TO means never.
  task automatic run_txn(input logic [31:0] instr, input logic [63:0] alu,
                         input logic [63:0] sd, input int ack_at, input logic [63:0] rdata);
    int          nbytes;
    int          off;
    bit          ld, st, mis, acked;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata, e_load;
    ld     = (instr[6:0] == 7'b0000011);
    st     = (instr[6:0] == 7'b0100011);
    nbytes = 1 << instr[13:12];
    off    = int'(alu % 8);
    mis    = (ld || st) && ((alu % nbytes) != 0);
    e_strb = '0;
    e_wdata = '0;
    e_load = '0;
    for (int b = 0; b < 8; b++) begin
      if (st && b >= off && b < off + nbytes) e_strb[b] = 1'b1;
      if (b >= off) e_wdata[8*b +: 8] = sd[8*(b-off) +: 8];
      if (b + off < 8) e_load[8*b +: 8] = rdata[8*(b+off) +: 8];
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_instruction = instr; in_alu_result = alu; in_store_data = sd;
    @(negedge clk);
    in_valid = 1'b0;
    if (!(ld || st) || mis) begin
      chk("wb_valid_direct", wb_valid, 1);
      chk("wb_data_direct", wb_data, (ld || st) ? 64'd0 : alu);
      chk("wb_instr_direct", wb_instruction, instr);
      chk("wb_misalign", wb_misalign, mis);
      chk("wb_bus_err_direct", wb_bus_err, 0);
      chk("no_req_direct", dmem_req, 0);
    end else begin
      acked = 0;
      for (int k = 0; k < TO; k++) begin
        chk("req_held", dmem_req, 1);
        chk("in_ready_bus", in_ready, 0);
        chk("wb_valid_bus", wb_valid, 0);
        chk("dmem_addr", dmem_addr, alu & ~64'd7);
        chk("dmem_we", dmem_we, st);
        chk("dmem_wstrb", dmem_wstrb, e_strb);
        if (st) chk("dmem_wdata", dmem_wdata, e_wdata);
        dmem_ack = (k == ack_at);
        dmem_rdata = (k == ack_at) ? rdata : 64'(($urandom << 32) | $urandom);
        @(negedge clk);
        dmem_ack = 1'b0;
        if (k == ack_at) begin
          acked = 1;
          break;
        end
      end
      chk("wb_valid_mem", wb_valid, 1);
      chk("wb_data_mem", wb_data, (acked && ld) ? e_load : 64'd0);
      chk("wb_instr_mem", wb_instruction, instr);
      chk("wb_bus_err", wb_bus_err, !acked);
      chk("wb_misalign_mem", wb_misalign, 0);
      chk("req_drop", dmem_req, 0);
      chk("in_ready_back", in_ready, 1);
    end
  endtask

  initial begin
    logic [31:0] ia, ib;
    logic [2:0]  f3;
    logic [63:0] a, d;
    int kind;
    rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_alu_result = '0;
    in_store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_instr", wb_instruction, 0);
    chk("rst_misalign", wb_misalign, 0);
    chk("rst_bus_err", wb_bus_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back non-memory instructions
    ia = mk_instr(7'b0110011, 3'b000);
    ib = mk_instr(7'b0010011, 3'b000);
    in_valid = 1'b1; in_instruction = ia; in_alu_result = 64'h1234;
    @(negedge clk);
    chk("b2b_valid0", wb_valid, 1);
    chk("b2b_data0", wb_data, 64'h1234);
    chk("b2b_ready", in_ready, 1);
    in_instruction = ib; in_alu_result = 64'h5678_9ABC;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid1", wb_valid, 1);
    chk("b2b_data1", wb_data, 64'h5678_9ABC);
    chk("b2b_instr1", wb_instruction, ib);
    chk("b2b_noreq", dmem_req, 0);
    @(negedge clk);
    chk("b2b_pulse_end", wb_valid, 0);

    // lb at 0x1005, ack on third wait cycle
    run_txn(mk_instr(7'b0000011, 3'b000), 64'h1005, 64'd0, 2, 64'h8877_6655_4433_2211);
    // sh at 0x2006
    run_txn(mk_instr(7'b0100011, 3'b001), 64'h2006, 64'hBEEF, 1, 64'd0);
    // lw at 0x3002: misaligned
    run_txn(mk_instr(7'b0000011, 3'b010), 64'h3002, 64'd0, 0, 64'd0);
    // ld, no ack: timeout
    run_txn(mk_instr(7'b0000011, 3'b011), 64'h4000, 64'd0, TO, 64'd0);
    // ld, ack in the final wait cycle wins
    run_txn(mk_instr(7'b0000011, 3'b011), 64'h4008, 64'd0, TO - 1, 64'hDEAD_BEEF_CAFE_F00D);
    // sd with ack immediately
    run_txn(mk_instr(7'b0100011, 3'b011), 64'h5010, 64'h0123_4567_89AB_CDEF, 0, 64'd0);

    // Reset during BUS, then a late ack
    in_valid = 1'b1; in_instruction = mk_instr(7'b0000011, 3'b011); in_alu_result = 64'h6000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstmid_req_before", dmem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req", dmem_req, 0);
    chk("rstmid_wb_valid", wb_valid, 0);
    chk("rstmid_wb_data", wb_data, 0);
    chk("rstmid_wb_instr", wb_instruction, 0);
    chk("rstmid_ready", in_ready, 1);
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_no_wb", wb_valid, 0);
    chk("late_ack_no_req", dmem_req, 0);
    @(negedge clk);
    chk("late_ack_no_wb2", wb_valid, 0);

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      case (kind)
        0: ia = mk_instr(7'b0110011, f3);
        1: ia = mk_instr(7'b0000011, f3);
        default: ia = mk_instr(7'b0100011, f3);
      endcase
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      run_txn(ia, a, d, $urandom_range(0, TO + 1), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
